// File: rtl/seg4_decode_if.sv
// Scan-sample input bus and decoded-result output bus of the two-digit seven-segment decoder.
interface seg4_decode_if;
  logic       scan_valid;
  logic       scan_sel;
  logic [7:0] scan_seg;
  logic       val_valid;
  logic       val_ready;
  logic [3:0] val_data;
  logic       val_err;
  logic [3:0] err_cnt;

  modport master (
    output scan_valid,
    output scan_sel,
    output scan_seg,
    output val_ready,
    input  val_valid,
    input  val_data,
    input  val_err,
    input  err_cnt
  );

  modport slave (
    input  scan_valid,
    input  scan_sel,
    input  scan_seg,
    input  val_ready,
    output val_valid,
    output val_data,
    output val_err,
    output err_cnt
  );
endinterface

// File: rtl/seg4_decode.sv
// Debounced sign+magnitude seven-segment decoder: result valid two cycles after the completing sign
// sample, held in HOLD until val_ready; scan samples arriving outside COLLECT are dropped, never buffered.
module seg4_decode (
  input  logic         clk,
  input  logic         rst_n,
  seg4_decode_if.slave bus
);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_EVAL    = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [7:0]  r_mag_raw;
  logic [7:0]  r_sign_raw;
  logic        r_have_mag;
  logic [15:0] r_prev_frame;
  logic        r_prev_ok;
  logic [4:0]  r_last_out;
  logic        r_emitted;
  logic [3:0]  r_val_data;
  logic        r_val_err;
  logic [3:0]  r_err_cnt;

  logic        w_mag_take;
  logic        w_sign_take;
  logic        w_in_eval;
  logic        w_val_valid;
  logic [7:0]  w_mag_p;
  logic [7:0]  w_sign_p;
  logic [15:0] w_frame;
  logic        w_mag_ok;
  logic [3:0]  w_mag_dig;
  logic        w_sign_pos;
  logic        w_sign_neg;
  logic        w_res_err;
  logic [4:0]  w_neg_dig;
  logic [3:0]  w_res_data;
  logic        w_stable;
  logic        w_emit;

  // Returns {valid, digit} for a dp-masked, active-high segment pattern.
  function automatic logic [4:0] f_mag_decode(input logic [7:0] p);
    logic [4:0] res;
    case (p)
      8'hFC:   res = {1'b1, 4'd0};
      8'h60:   res = {1'b1, 4'd1};
      8'hDA:   res = {1'b1, 4'd2};
      8'hF2:   res = {1'b1, 4'd3};
      8'h66:   res = {1'b1, 4'd4};
      8'hB6:   res = {1'b1, 4'd5};
      8'hBE:   res = {1'b1, 4'd6};
      8'hE0:   res = {1'b1, 4'd7};
      8'hFE:   res = {1'b1, 4'd8};
      default: res = {1'b0, 4'd0};
    endcase
    return res;
  endfunction

  assign w_mag_take  = (r_state == S_COLLECT) && bus.scan_valid && !bus.scan_sel;
  assign w_sign_take = (r_state == S_COLLECT) && bus.scan_valid && bus.scan_sel && r_have_mag;

  assign w_mag_p  = ~r_mag_raw  & 8'hFE;
  assign w_sign_p = ~r_sign_raw & 8'hFE;
  assign w_frame  = {w_sign_p, w_mag_p};

  assign {w_mag_ok, w_mag_dig} = f_mag_decode(w_mag_p);
  assign w_sign_pos = (w_sign_p == 8'h00);
  assign w_sign_neg = (w_sign_p == 8'h02);

  assign w_res_err = !w_mag_ok
                   || !(w_sign_pos || w_sign_neg)
                   || (w_sign_pos && (w_mag_dig == 4'd8))
                   || (w_sign_neg && (w_mag_dig == 4'd0));

  // Negation modulo 16; -8 falls out naturally as 4'b1000.
  assign w_neg_dig  = 5'd16 - {1'b0, w_mag_dig};
  assign w_res_data = w_res_err  ? 4'd0
                    : w_sign_neg ? w_neg_dig[3:0]
                    :              w_mag_dig;

  assign w_stable = r_prev_ok && (w_frame == r_prev_frame);
  assign w_emit   = w_stable && (!r_emitted || ({w_res_err, w_res_data} != r_last_out));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_COLLECT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_COLLECT: if (w_sign_take)     w_state_nxt = S_EVAL;
      S_EVAL:    w_state_nxt = w_emit ? S_HOLD : S_COLLECT;
      S_HOLD:    if (bus.val_ready)   w_state_nxt = S_COLLECT;
      default:   w_state_nxt = S_COLLECT;
    endcase
  end

  always_comb begin
    w_val_valid = 1'b0;
    w_in_eval   = 1'b0;
    case (r_state)
      S_EVAL:  w_in_eval   = 1'b1;
      S_HOLD:  w_val_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mag_raw    <= 8'h00;
      r_sign_raw   <= 8'h00;
      r_have_mag   <= 1'b0;
      r_prev_frame <= 16'h0000;
      r_prev_ok    <= 1'b0;
      r_last_out   <= 5'd0;
      r_emitted    <= 1'b0;
      r_val_data   <= 4'd0;
      r_val_err    <= 1'b0;
      r_err_cnt    <= 4'd0;
    end else begin
      if (w_mag_take) begin
        r_mag_raw  <= bus.scan_seg;
        r_have_mag <= 1'b1;
      end
      if (w_sign_take) begin
        r_sign_raw <= bus.scan_seg;
      end
      if (w_in_eval) begin
        r_prev_frame <= w_frame;
        r_prev_ok    <= 1'b1;
        r_have_mag   <= 1'b0;
        if (w_emit) begin
          r_val_data <= w_res_data;
          r_val_err  <= w_res_err;
          r_last_out <= {w_res_err, w_res_data};
          r_emitted  <= 1'b1;
          if (w_res_err && (r_err_cnt != 4'hF)) begin
            r_err_cnt <= r_err_cnt + 4'd1;
          end
        end
      end
    end
  end

  assign bus.val_valid = w_val_valid;
  assign bus.val_data  = r_val_data;
  assign bus.val_err   = r_val_err;
  assign bus.err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_seg4_decode.sv
// Randomized and directed bench for seg4_decode against a frame-level reference model.
module tb_seg4_decode;

  logic clk;
  logic rst_n;

  seg4_decode_if u_if ();

  seg4_decode u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  logic [7:0] seg_tbl [9] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0, 8'hFE};

  logic [15:0] ref_prev;
  bit          ref_prev_ok;
  bit          ref_emitted;
  logic [4:0]  ref_last;
  int          ref_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int digit_of(input logic [7:0] p);
    for (int i = 0; i < 9; i++) begin
      if (seg_tbl[i] == p) return i;
    end
    return -1;
  endfunction

  // {err, data} that a complete frame of raw active-low samples should produce.
  function automatic logic [4:0] ref_result(input logic [7:0] mag_seg, input logic [7:0] sign_seg);
    logic [7:0] mp;
    logic [7:0] sp;
    int d;
    int v;
    bit pos;
    bit neg;
    mp  = ~mag_seg & 8'hFE;
    sp  = ~sign_seg & 8'hFE;
    d   = digit_of(mp);
    pos = (sp == 8'h00);
    neg = (sp == 8'h02);
    if (d < 0 || !(pos || neg) || (pos && d == 8) || (neg && d == 0)) return 5'b10000;
    v = neg ? (16 - d) % 16 : d;
    return {1'b0, 4'(v)};
  endfunction

  task automatic model_reset();
    ref_prev_ok = 1'b0;
    ref_emitted = 1'b0;
    ref_last    = 5'd0;
    ref_cnt     = 0;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    #2 rst_n = 1'b0;
    u_if.scan_valid = 1'b0;
    #1;
    chk("rst_vld", u_if.val_valid, 0);
    chk("rst_dat", u_if.val_data, 0);
    chk("rst_err", u_if.val_err, 0);
    chk("rst_cnt", u_if.err_cnt, 0);
    model_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Drives one frame (optionally preceded by an ignored sign sample and an overwritten magnitude).
  task automatic send_frame(input logic [7:0] mag, input logic [7:0] sign, input bit ready,
                            input bit stray, input bit extra, output bit emit);
    logic [4:0]  res;
    logic [15:0] key;
    bit          stable;
    if (stray) begin
      @(negedge clk);
      u_if.val_ready  = ready;
      u_if.scan_valid = 1'b1;
      u_if.scan_sel   = 1'b1;
      u_if.scan_seg   = 8'($urandom);
    end
    if (extra) begin
      @(negedge clk);
      u_if.val_ready  = ready;
      u_if.scan_valid = 1'b1;
      u_if.scan_sel   = 1'b0;
      u_if.scan_seg   = 8'($urandom);
    end
    @(negedge clk);
    u_if.val_ready  = ready;
    u_if.scan_valid = 1'b1;
    u_if.scan_sel   = 1'b0;
    u_if.scan_seg   = mag;
    @(negedge clk);
    u_if.scan_sel   = 1'b1;
    u_if.scan_seg   = sign;
    @(negedge clk);
    u_if.scan_valid = 1'b0;
    chk("eval_vld", u_if.val_valid, 0);

    res    = ref_result(mag, sign);
    key    = {~sign & 8'hFE, ~mag & 8'hFE};
    stable = ref_prev_ok && (key == ref_prev);
    emit   = stable && (!ref_emitted || res != ref_last);
    if (emit) begin
      ref_emitted = 1'b1;
      ref_last    = res;
      if (res[4] && ref_cnt < 15) ref_cnt++;
    end
    ref_prev    = key;
    ref_prev_ok = 1'b1;

    @(negedge clk);
    chk("emit_vld", u_if.val_valid, 32'(emit));
    if (emit) chk("emit_res", {u_if.val_err, u_if.val_data}, res);
    chk("err_cnt", u_if.err_cnt, ref_cnt);
    if (emit && ready) begin
      @(negedge clk);
      chk("drop_vld", u_if.val_valid, 0);
    end
  endtask

  // While stalled in HOLD, throw scan samples at the DUT and confirm the result does not move.
  task automatic hold_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("hold_vld", u_if.val_valid, 1);
      chk("hold_res", {u_if.val_err, u_if.val_data}, ref_last);
      u_if.val_ready  = 1'b0;
      u_if.scan_valid = 1'b1;
      u_if.scan_sel   = 1'($urandom_range(0, 1));
      u_if.scan_seg   = 8'($urandom);
    end
  endtask

  task automatic release_hold();
    @(negedge clk);
    u_if.scan_valid = 1'b0;
    chk("rel_vld", u_if.val_valid, 1);
    u_if.val_ready  = 1'b1;
    @(negedge clk);
    chk("rel_drop", u_if.val_valid, 0);
  endtask

  initial begin
    bit          e;
    logic [7:0]  m;
    logic [7:0]  s;
    logic [7:0]  pm;
    logic [7:0]  ps;
    int          r;
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b1;
    u_if.scan_valid = 1'b0;
    u_if.scan_sel   = 1'b0;
    u_if.scan_seg   = 8'hFF;
    u_if.val_ready  = 1'b1;
    model_reset();
    ref_prev = 16'h0;

    reset_pulse();

    // +4, first frame only primes the history
    send_frame(8'h99, 8'hFF, 1'b1, 1'b0, 1'b0, e);
    send_frame(8'h99, 8'hFF, 1'b1, 1'b0, 1'b0, e);
    chk("pos4_emit", 32'(e), 1);

    // -8, repeat, then dp-lit repeat
    send_frame(8'h01, 8'hFD, 1'b1, 1'b0, 1'b0, e);
    send_frame(8'h01, 8'hFD, 1'b1, 1'b0, 1'b0, e);
    chk("neg8_emit", 32'(e), 1);
    send_frame(8'h01, 8'hFD, 1'b1, 1'b0, 1'b0, e);
    send_frame(8'h00, 8'hFC, 1'b1, 1'b0, 1'b0, e);
    chk("dp_noemit", 32'(e), 0);

    // -3/+3 flicker never settles, then +8 is an error
    for (int i = 0; i < 10; i++) begin
      send_frame(8'h0D, (i % 2 == 0) ? 8'hFD : 8'hFF, 1'b1, 1'b0, 1'b0, e);
    end
    send_frame(8'h01, 8'hFF, 1'b1, 1'b0, 1'b0, e);
    send_frame(8'h01, 8'hFF, 1'b1, 1'b0, 1'b0, e);
    chk("pos8_cnt", u_if.err_cnt, 1);

    // -5 stalled by the consumer, then reset while holding
    send_frame(8'h49, 8'hFD, 1'b0, 1'b0, 1'b0, e);
    send_frame(8'h49, 8'hFD, 1'b0, 1'b0, 1'b0, e);
    hold_check(10);
    chk("neg5_res", {u_if.val_err, u_if.val_data}, 5'b01011);
    reset_pulse();
    u_if.val_ready = 1'b1;
    send_frame(8'h49, 8'hFD, 1'b1, 1'b0, 1'b0, e);
    @(negedge clk);
    u_if.scan_valid = 1'b1;
    u_if.scan_sel   = 1'b0;
    u_if.scan_seg   = 8'h49;
    reset_pulse();
    @(negedge clk);
    u_if.scan_valid = 1'b1;
    u_if.scan_sel   = 1'b1;
    u_if.scan_seg   = 8'hFD;
    @(negedge clk);
    u_if.scan_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_vld", u_if.val_valid, 0);
    send_frame(8'h49, 8'hFD, 1'b1, 1'b0, 1'b0, e);
    chk("post_rst_first", 32'(e), 0);
    send_frame(8'h49, 8'hFD, 1'b1, 1'b0, 1'b0, e);
    chk("post_rst_second", 32'(e), 1);

    // error results separated by valid ones so every error pair re-emits
    for (int i = 0; i < 16; i++) begin
      m = (i % 2 == 0) ? 8'h01 : 8'($urandom_range(0, 255) | 8'h80);
      send_frame(m, 8'hFF, 1'b1, 1'b0, 1'b0, e);
      send_frame(m, 8'hFF, 1'b1, 1'b0, 1'b0, e);
      send_frame(8'h9F, 8'hFF, 1'b1, 1'b0, 1'b0, e);
      send_frame(8'h9F, 8'hFF, 1'b1, 1'b0, 1'b0, e);
    end
    chk("sat_cnt", u_if.err_cnt, 15);

    // randomized frames, frequently repeated so emissions occur
    pm = 8'h03;
    ps = 8'hFF;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        m = pm;
        s = ps;
      end else begin
        r = $urandom_range(0, 9);
        m = (r < 9) ? ~seg_tbl[r] : 8'($urandom);
        r = $urandom_range(0, 4);
        s = (r < 2) ? 8'hFF : (r < 4) ? 8'hFD : 8'($urandom);
      end
      m[0] = 1'($urandom_range(0, 1));
      s[0] = 1'($urandom_range(0, 1));
      send_frame(m, s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), e);
      if (u_if.val_valid) begin
        hold_check($urandom_range(1, 3));
        release_hold();
      end
      pm = m;
      ps = s;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seg4_decode.md
SEG4_DECODE -- requirements
Module: seg4_decode

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 scan_valid  input  1  scan_seg/scan_sel carry a digit sample this cycle.
REQ-004 scan_sel  input  1  0 = magnitude digit, 1 = sign digit.
REQ-005 scan_seg  input  8  active-low segments {a,b,c,d,e,f,g,dp}, bit7 = a, bit0 = dp.
REQ-006 val_valid  output  1  decoded result available.
REQ-007 val_ready  input  1  consumer accepts the result.
REQ-008 val_data  output  4  decoded value, 4-bit two's complement.
REQ-009 val_err  output  1  frame undecodable; val_data = 4'b0000 when set.
REQ-010 err_cnt  output  4  count of emitted error results, saturating at 15.

Function
REQ-011 Patterns are compared as p = ~scan_seg with bit0 (dp) masked to 0.
REQ-012 Magnitude digit decode: 0xFC=0, 0x60=1, 0xDA=2, 0xF2=3, 0x66=4, 0xB6=5, 0xBE=6, 0xE0=7, 0xFE=8; any other pattern is invalid.
REQ-013 Sign digit decode: 0x00 = positive, 0x02 = negative; any other pattern is invalid.
REQ-014 Value rules: positive with 0..7 gives d; negative with 1..7 gives (16-d) mod 16; negative with 8 gives 4'b1000.
REQ-015 Error rules: positive with 8, negative with 0, or any invalid digit give val_err=1 and val_data=0.
REQ-016 FSM has three states: COLLECT, EVAL, HOLD; reset state is COLLECT.
REQ-017 COLLECT, scan_valid and scan_sel=0: latch mag_raw and set have_mag; a later magnitude sample overwrites mag_raw.
REQ-018 COLLECT, scan_valid and scan_sel=1 with have_mag=0: ignore the sample.
REQ-019 COLLECT, scan_valid and scan_sel=1 with have_mag=1: latch sign_raw, completing a frame; next state is EVAL.
REQ-020 EVAL lasts exactly one cycle.
REQ-021 EVAL sets stable=1 when prev_ok=1 and the masked {sign,mag} frame equals prev_frame.
REQ-022 EVAL emits when stable=1 and the result {err,data} differs from last_out, or nothing has been emitted since reset.
REQ-023 EVAL, emit: load val_data/val_err and last_out, increment err_cnt if val_err, go to HOLD.
REQ-024 EVAL, no emit: go to COLLECT.
REQ-025 EVAL always updates prev_frame to the current frame, sets prev_ok=1 and clears have_mag.
REQ-026 Latency: the sign sample completing the frame is registered at edge t, EVAL runs in cycle t+1, val_valid is high from cycle t+2.
REQ-027 HOLD: val_valid=1 with val_data/val_err stable until a cycle with val_ready=1; then go to COLLECT, and val_valid is low the next cycle.
REQ-028 EVAL and HOLD ignore all scan samples; no sample is buffered.
REQ-029 val_ready is ignored while val_valid=0.
REQ-030 err_cnt holds at 15 once saturated.

Reset
REQ-031 rst_n low asynchronously forces: state=COLLECT, val_valid=0, val_data=0, val_err=0, err_cnt=0, have_mag=0, prev_ok=0, emitted flag=0.
REQ-032 Reset taken mid-frame or in HOLD discards the partial frame or pending result; no output results from the discarded data.
REQ-033 After rst_n deasserts, two identical complete frames are required before the first emission.

Verification
REQ-034 Reset: assert rst_n=0 asynchronously between edges -> all outputs 0 immediately, err_cnt=0.
REQ-035 Positive value: two frames mag=~0x66, sign=~0x00 with val_ready=1 -> single val_valid pulse 2 cycles after the second sign sample, val_data=4'b0100, val_err=0.
REQ-036 Repeats and -8: two frames mag=~0xFE, sign=~0x02 -> val_data=4'b1000; a third identical frame -> no emission; the same frame with dp bit cleared (dp lit) -> no emission.
REQ-037 Instability and error: frames alternate -3 (~0xF2/~0x02) and +3 (~0xF2/~0x00) ten times -> no emission; then two frames mag=~0xFE, sign=~0x00 -> val_err=1, val_data=0, err_cnt=1.
REQ-038 Backpressure and reset: emit -5 (4'b1011) with val_ready=0 for 10 cycles while driving other frames -> val_valid and val_data held, the other samples ignored; then pulse rst_n low in HOLD -> val_valid=0 at once, and no emission until two new identical frames arrive.
REQ-039 Saturation: sixteen alternating distinct error frame pairs -> err_cnt reaches 15 and stays at 15.
